// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file and its UART word packer.
// Optional same-cycle read bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

   localparam int DATA_W_DEF     = 32;
   localparam int ADDR_W_DEF     = 5;
   localparam int NUM_WR_DEF     = 3;
   localparam int UART_REG0_DEF  = 16;
   localparam int UART_REG1_DEF  = 17;
   localparam int RESULT_REG_DEF = 2;

   typedef enum logic {
      PK_IDLE    = 1'b0,
      PK_COLLECT = 1'b1
   } pk_state_e;

   function automatic int bytes_per_word(input int width);
      return width / 8;
   endfunction

endpackage

// File: rtl/uart_word_packer.sv
// Assembles little-endian UART bytes into a register-wide word and raises a
// one-cycle mailbox write strobe in the cycle the final byte arrives.
module uart_word_packer
   import regfile_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int UART_REG0 = UART_REG0_DEF,
   parameter int UART_REG1 = UART_REG1_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_valid_i,
   input  logic [7:0]        rx_data_i,
   input  logic              rx_sel_i,
   input  logic              rx_flush_i,
   output logic              mb_we_o,
   output logic [ADDR_W-1:0] mb_addr_o,
   output logic [DATA_W-1:0] mb_word_o,
   output pk_state_e         state_o
);

   localparam int BYTES = bytes_per_word(DATA_W);
   localparam int CNT_W = $clog2(BYTES + 1);

   pk_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sel_q, sel_d;
   logic [DATA_W-1:0] stage_q, stage_d;
   logic              last_byte;

   // Flush outranks a simultaneous byte; a select change restarts the word.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sel_d     = sel_q;
      stage_d   = stage_q;
      last_byte = 1'b0;
      if (rx_flush_i) begin
         state_d = PK_IDLE;
         cnt_d   = '0;
      end else if (rx_valid_i) begin
         if (BYTES == 1) begin
            stage_d   = DATA_W'(rx_data_i);
            sel_d     = rx_sel_i;
            last_byte = 1'b1;
         end else if (state_q == PK_IDLE || rx_sel_i != sel_q) begin
            stage_d = DATA_W'(rx_data_i);
            sel_d   = rx_sel_i;
            cnt_d   = CNT_W'(1);
            state_d = PK_COLLECT;
         end else begin
            stage_d[cnt_q*8 +: 8] = rx_data_i;
            if (cnt_q == CNT_W'(BYTES - 1)) begin
               last_byte = 1'b1;
               state_d   = PK_IDLE;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= PK_IDLE;
         cnt_q   <= '0;
         sel_q   <= 1'b0;
         stage_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         stage_q <= stage_d;
      end
   end

   // On the final byte the select matches the latched one, so the live input is enough.
   assign mb_we_o   = last_byte;
   assign mb_word_o = stage_d;
   assign mb_addr_o = rx_sel_i ? ADDR_W'(UART_REG0) : ADDR_W'(UART_REG1);
   assign state_o   = state_q;

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file with prioritised writes, UART mailbox packer and
// registered result byte. Define REGFILE_BYPASS_EN for write-before-read.
module regfile_multiport
   import regfile_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int NUM_WR     = NUM_WR_DEF,
   parameter int UART_REG0  = UART_REG0_DEF,
   parameter int UART_REG1  = UART_REG1_DEF,
   parameter int RESULT_REG = RESULT_REG_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0]        rd_addr1,
   input  logic [ADDR_W-1:0]        rd_addr2,
   output logic [DATA_W-1:0]        rd_data1,
   output logic [DATA_W-1:0]        rd_data2,
   input  logic                     rx_valid,
   input  logic [7:0]               rx_data,
   input  logic                     rx_sel,
   input  logic                     rx_flush,
   output logic                     word_done,
   output logic [7:0]               result_data,
   output pk_state_e                dbg_pk_state
);

   localparam int NREGS = 2**ADDR_W;

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic [7:0]        result_q;
   logic              mb_we;
   logic [ADDR_W-1:0] mb_addr;
   logic [DATA_W-1:0] mb_word;

   uart_word_packer #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .UART_REG0 (UART_REG0),
      .UART_REG1 (UART_REG1)
   ) u_packer (
      .clk        (clk),
      .reset      (reset),
      .rx_valid_i (rx_valid),
      .rx_data_i  (rx_data),
      .rx_sel_i   (rx_sel),
      .rx_flush_i (rx_flush),
      .mb_we_o    (mb_we),
      .mb_addr_o  (mb_addr),
      .mb_word_o  (mb_word),
      .state_o    (dbg_pk_state)
   );

   // Apply lowest-priority sources first so later assignments win; mailbox is last.
   always_comb begin
      regs_d = regs_q;
      for (int i = NUM_WR - 1; i >= 0; i--) begin
         if (wr_en[i] && wr_addr[i*ADDR_W +: ADDR_W] != '0) begin
            regs_d[wr_addr[i*ADDR_W +: ADDR_W]] = wr_data[i*DATA_W +: DATA_W];
         end
      end
      if (mb_we) begin
         regs_d[mb_addr] = mb_word;
      end
      regs_d[0] = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NREGS; k++) begin
            regs_q[k] <= '0;
         end
         result_q <= '0;
      end else begin
         regs_q   <= regs_d;
         result_q <= regs_q[RESULT_REG][7:0];
      end
   end

`ifdef REGFILE_BYPASS_EN
   assign rd_data1 = (rd_addr1 == '0) ? '0 : regs_d[rd_addr1];
   assign rd_data2 = (rd_addr2 == '0) ? '0 : regs_d[rd_addr2];
`else
   assign rd_data1 = (rd_addr1 == '0) ? '0 : regs_q[rd_addr1];
   assign rd_data2 = (rd_addr2 == '0) ? '0 : regs_q[rd_addr2];
`endif

   assign word_done   = mb_we;
   assign result_data = result_q;

endmodule
